// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param: parametrised image-window processor.
// Loads an IMG_W x IMG_H image from IROM into an internal pixel buffer, applies
// host commands to a 2x2 window, and streams the buffer to IRAM on cmd 0.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   cmd         command code, latched when cmd_valid=1 and busy=0
//   cmd_valid   command qualifier
//   IROM_Q      ROM read data for IROM_A (same cycle)
//   IROM_rd     ROM read enable (high only while loading)
//   IROM_A      ROM address
//   IRAM_valid  RAM write strobe
//   IRAM_D      RAM write data
//   IRAM_A      RAM write address
//   busy        high whenever cmd is ignored
//   done        one-cycle pulse after a complete write-out
module lcd_ctrl_param #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] IROM_Q,
  output logic          IROM_rd,
  output logic [AW-1:0] IROM_A,
  output logic          IRAM_valid,
  output logic [DW-1:0] IRAM_D,
  output logic [AW-1:0] IRAM_A,
  output logic          busy,
  output logic          done
);

  localparam int N  = IMG_W * IMG_H;
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int SW = DW + 2;

  localparam logic [RW-1:0] ROW0    = RW'(IMG_H / 2 - 1);
  localparam logic [CW-1:0] COL0    = CW'(IMG_W / 2 - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 2);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 2);
  localparam logic [AW-1:0] LAST    = AW'(N - 1);

  typedef enum logic [2:0] {
    S_LOAD, S_CMD, S_OP, S_WRITE, S_DONE
  } state_t;

  typedef enum logic [3:0] {
    C_WRITE  = 4'h0, C_UP    = 4'h1, C_DOWN  = 4'h2, C_LEFT   = 4'h3,
    C_RIGHT  = 4'h4, C_MAX   = 4'h5, C_MIN   = 4'h6, C_AVG    = 4'h7,
    C_CCW    = 4'h8, C_CW    = 4'h9, C_MIRX  = 4'hA, C_MIRY   = 4'hB,
    C_CENTRE = 4'hC, C_INV   = 4'hD, C_NOP_E = 4'hE, C_NOP_F  = 4'hF
  } cmd_t;

  state_t          state, state_nx;
  cmd_t            cmd_q;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [DW-1:0]   pix [N];

  logic [AW-1:0]   idx0, idx1, idx2, idx3;
  logic [DW-1:0]   p0, p1, p2, p3;
  logic [DW-1:0]   np0, np1, np2, np3;
  logic [DW-1:0]   mx01, mx23, mx, mn01, mn23, mn, avg;
  logic [SW-1:0]   sum;
  logic [AW-1:0]   wr_nx;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:  if (IROM_A == LAST) state_nx = S_CMD;
      S_CMD:   if (cmd_valid) state_nx = (cmd == 4'h0) ? S_WRITE : S_OP;
      S_OP:    state_nx = S_CMD;
      S_WRITE: if (IRAM_A == LAST) state_nx = S_DONE;
      S_DONE:  state_nx = S_CMD;
      default: state_nx = S_LOAD;
    endcase
  end

  assign busy = (state != S_CMD);
  assign done = (state == S_DONE);

  // ---------------------------------------------------------------- command latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          cmd_q <= C_WRITE;
    else if (state == S_CMD && cmd_valid) cmd_q <= cmd_t'(cmd);
  end

  // ---------------------------------------------------------------- ROM side
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IROM_rd <= 1'b1;
      IROM_A  <= '0;
    end else if (state == S_LOAD) begin
      if (IROM_A == LAST) begin
        IROM_rd <= 1'b0;
        IROM_A  <= '0;
      end else begin
        IROM_A  <= IROM_A + AW'(1);
      end
    end
  end

  // ---------------------------------------------------------------- RAM side
  assign wr_nx = IRAM_A + AW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IRAM_valid <= 1'b0;
      IRAM_A     <= '0;
      IRAM_D     <= '0;
    end else begin
      case (state)
        S_CMD: begin
          if (state_nx == S_WRITE) begin
            IRAM_valid <= 1'b1;
            IRAM_A     <= '0;
            IRAM_D     <= pix[0];
          end
        end
        S_WRITE: begin
          if (IRAM_A == LAST) begin
            IRAM_valid <= 1'b0;
            IRAM_A     <= '0;
          end else begin
            IRAM_A     <= wr_nx;
            IRAM_D     <= pix[wr_nx];
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- window origin
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= ROW0;
      col <= COL0;
    end else if (state == S_OP) begin
      case (cmd_q)
        C_UP:     if (row != '0)     row <= row - RW'(1);
        C_DOWN:   if (row < ROW_MAX) row <= row + RW'(1);
        C_LEFT:   if (col != '0)     col <= col - CW'(1);
        C_RIGHT:  if (col < COL_MAX) col <= col + CW'(1);
        C_CENTRE: begin
          row <= ROW0;
          col <= COL0;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- window datapath
  always_comb begin
    idx0 = AW'(row) * AW'(IMG_W) + AW'(col);
    idx1 = idx0 + AW'(1);
    idx2 = idx0 + AW'(IMG_W);
    idx3 = idx2 + AW'(1);
    p0 = pix[idx0];
    p1 = pix[idx1];
    p2 = pix[idx2];
    p3 = pix[idx3];

    mx01 = (p0 > p1) ? p0 : p1;
    mx23 = (p2 > p3) ? p2 : p3;
    mx   = (mx01 > mx23) ? mx01 : mx23;
    mn01 = (p0 < p1) ? p0 : p1;
    mn23 = (p2 < p3) ? p2 : p3;
    mn   = (mn01 < mn23) ? mn01 : mn23;
    sum  = SW'(p0) + SW'(p1) + SW'(p2) + SW'(p3);
    avg  = DW'(sum >> 2);

    // Every OP cycle rewrites all four window pixels; commands that do not
    // touch pixel data simply write back the current values.
    np0 = p0;
    np1 = p1;
    np2 = p2;
    np3 = p3;
    case (cmd_q)
      C_MAX: begin np0 = mx;  np1 = mx;  np2 = mx;  np3 = mx;  end
      C_MIN: begin np0 = mn;  np1 = mn;  np2 = mn;  np3 = mn;  end
      C_AVG: begin np0 = avg; np1 = avg; np2 = avg; np3 = avg; end
      C_CCW: begin np0 = p1;  np1 = p3;  np2 = p0;  np3 = p2;  end
      C_CW:  begin np0 = p2;  np1 = p0;  np2 = p3;  np3 = p1;  end
      C_MIRX: begin np0 = p2; np1 = p3;  np2 = p0;  np3 = p1;  end
      C_MIRY: begin np0 = p1; np1 = p0;  np2 = p3;  np3 = p2;  end
      C_INV: begin np0 = ~p0; np1 = ~p1; np2 = ~p2; np3 = ~p3; end
      default: ;
    endcase
  end

  // Pixel buffer: no reset, contents are reloaded after every reset.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      pix[IROM_A] <= IROM_Q;
    end else if (state == S_OP) begin
      pix[idx0] <= np0;
      pix[idx1] <= np1;
      pix[idx2] <= np2;
      pix[idx3] <= np3;
    end
  end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
module tb_lcd_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- DUT A: 8x8, DW=8
  logic       rst_a, cv_a, rd_a, wv_a, busy_a, done_a;
  logic [3:0] cmd_a;
  logic [7:0] q_a, wd_a;
  logic [5:0] ra_a, wa_a;
  logic [7:0] rom_a [64];
  logic [7:0] cap_a [64];
  assign q_a = rom_a[ra_a];

  lcd_ctrl_param #(.IMG_W(8), .IMG_H(8), .DW(8), .AW(6)) dut_a (
    .clk(clk), .reset(rst_a), .cmd(cmd_a), .cmd_valid(cv_a), .IROM_Q(q_a),
    .IROM_rd(rd_a), .IROM_A(ra_a), .IRAM_valid(wv_a), .IRAM_D(wd_a),
    .IRAM_A(wa_a), .busy(busy_a), .done(done_a));

  // ---------------- DUT B: 16x4, DW=10
  logic       rst_b, cv_b, rd_b, wv_b, busy_b, done_b;
  logic [3:0] cmd_b;
  logic [9:0] q_b, wd_b;
  logic [5:0] ra_b, wa_b;
  logic [9:0] rom_b [64];
  logic [9:0] cap_b [64];
  assign q_b = rom_b[ra_b];

  lcd_ctrl_param #(.IMG_W(16), .IMG_H(4), .DW(10), .AW(6)) dut_b (
    .clk(clk), .reset(rst_b), .cmd(cmd_b), .cmd_valid(cv_b), .IROM_Q(q_b),
    .IROM_rd(rd_b), .IROM_A(ra_b), .IRAM_valid(wv_b), .IRAM_D(wd_b),
    .IRAM_A(wa_b), .busy(busy_b), .done(done_b));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- drivers for DUT A
  task automatic wait_idle_a(output int n);
    n = 0;
    while (busy_a !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL idle_timeout_a: busy=%b after %0d cycles, required 0", busy_a, n);
    end
  endtask

  task automatic send_a(input logic [3:0] c);
    int n;
    wait_idle_a(n);
    cmd_a = c; cv_a = 1'b1;
    @(negedge clk);
    cv_a = 1'b0;
    wait_idle_a(n);
  endtask

  task automatic reload_a(output int n);
    rst_a = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_a = 1'b1;
    wait_idle_a(n);
  endtask

  task automatic fill_rom_a();
    for (int k = 0; k < 64; k++) rom_a[k] = 8'(k);
  endtask

  task automatic write_a(output int nwr, output int oerr, output bit seen,
                         output logic vd, output logic dn2, output logic bz2);
    int n = 0;
    int w;
    nwr = 0; oerr = 0; seen = 0; vd = 1'bx; dn2 = 1'bx; bz2 = 1'bx;
    for (int k = 0; k < 64; k++) cap_a[k] = 'x;
    wait_idle_a(w);
    cmd_a = 4'h0; cv_a = 1'b1;
    @(negedge clk);
    cv_a = 1'b0;
    while (!seen && n < 200) begin
      if (wv_a === 1'b1) begin
        if (wa_a !== 6'(nwr)) oerr++;
        cap_a[wa_a] = wd_a;
        nwr++;
      end
      if (done_a === 1'b1) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (seen) begin
      vd = wv_a;
      @(negedge clk);
      dn2 = done_a;
      bz2 = busy_a;
    end
  endtask

  // ---------------- drivers for DUT B
  task automatic wait_idle_b(output int n);
    n = 0;
    while (busy_b !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL idle_timeout_b: busy=%b after %0d cycles, required 0", busy_b, n);
    end
  endtask

  task automatic send_b(input logic [3:0] c);
    int n;
    wait_idle_b(n);
    cmd_b = c; cv_b = 1'b1;
    @(negedge clk);
    cv_b = 1'b0;
    wait_idle_b(n);
  endtask

  task automatic write_b(output int nwr, output bit seen);
    int n = 0;
    int w;
    nwr = 0; seen = 0;
    for (int k = 0; k < 64; k++) cap_b[k] = 'x;
    wait_idle_b(w);
    cmd_b = 4'h0; cv_b = 1'b1;
    @(negedge clk);
    cv_b = 1'b0;
    while (!seen && n < 200) begin
      if (wv_b === 1'b1) begin
        cap_b[wa_b] = wd_b;
        nwr++;
      end
      if (done_b === 1'b1) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  // ---------------- tests
  task automatic test_reset();
    rst_a = 1'b0;
    @(negedge clk); @(negedge clk);
    checks += 7;
    if (rd_a !== 1'b1)   begin failures++; $display("FAIL reset_irom_rd: got %b want 1", rd_a); end
    if (ra_a !== 6'd0)   begin failures++; $display("FAIL reset_irom_a: got %0d want 0", ra_a); end
    if (wv_a !== 1'b0)   begin failures++; $display("FAIL reset_iram_valid: got %b want 0", wv_a); end
    if (wa_a !== 6'd0)   begin failures++; $display("FAIL reset_iram_a: got %0d want 0", wa_a); end
    if (wd_a !== 8'd0)   begin failures++; $display("FAIL reset_iram_d: got %0d want 0", wd_a); end
    if (busy_a !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b want 1", busy_a); end
    if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done_a); end
  endtask

  task automatic test_load_write();
    int n, nwr, oerr, bad;
    bit seen;
    logic vd, dn2, bz2;
    fill_rom_a();
    rst_a = 1'b1;
    wait_idle_a(n);
    checks += 2;
    if (n !== 64)     begin failures++; $display("FAIL load_cycles: got %0d want 64", n); end
    if (rd_a !== 1'b0) begin failures++; $display("FAIL load_rd_drop: got %b want 0", rd_a); end
    write_a(nwr, oerr, seen, vd, dn2, bz2);
    bad = 0;
    for (int k = 0; k < 64; k++) if (cap_a[k] !== 8'(k)) bad++;
    checks += 7;
    if (nwr !== 64)   begin failures++; $display("FAIL write_count: got %0d want 64", nwr); end
    if (oerr !== 0)   begin failures++; $display("FAIL write_order: got %0d out-of-order want 0", oerr); end
    if (bad !== 0)    begin failures++; $display("FAIL write_data: got %0d bad pixels want 0", bad); end
    if (seen !== 1'b1) begin failures++; $display("FAIL done_seen: got %b want 1", seen); end
    if (vd !== 1'b0)  begin failures++; $display("FAIL done_valid_low: got %b want 0", vd); end
    if (dn2 !== 1'b0) begin failures++; $display("FAIL done_one_cycle: got %b want 0", dn2); end
    if (bz2 !== 1'b0) begin failures++; $display("FAIL busy_after_done: got %b want 0", bz2); end
  endtask

  task automatic test_reduce();
    int win [4] = '{27, 28, 35, 36};
    logic [3:0] cs [3] = '{4'h7, 4'h5, 4'h6};
    int ex [3] = '{11, 14, 10};
    int n, nwr, oerr;
    bit seen;
    logic vd, dn2, bz2;
    for (int t = 0; t < 3; t++) begin
      fill_rom_a();
      rom_a[27] = 8'd10; rom_a[28] = 8'd11; rom_a[35] = 8'd12; rom_a[36] = 8'd14;
      reload_a(n);
      send_a(cs[t]);
      write_a(nwr, oerr, seen, vd, dn2, bz2);
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (cap_a[win[j]] !== 8'(ex[t]))
          begin failures++; $display("FAIL reduce_cmd%0h_p%0d: got %0d want %0d", cs[t], j, cap_a[win[j]], ex[t]); end
      end
    end
  endtask

  task automatic test_rotate();
    int win [4] = '{27, 28, 35, 36};
    logic [3:0] cs [5] = '{4'h9, 4'h8, 4'hA, 4'hD, 4'hB};
    int ex [5][4] = '{'{3, 1, 4, 2}, '{1, 2, 3, 4}, '{3, 4, 1, 2},
                     '{252, 251, 254, 253}, '{251, 252, 253, 254}};
    int n, nwr, oerr;
    bit seen;
    logic vd, dn2, bz2;
    fill_rom_a();
    rom_a[27] = 8'd1; rom_a[28] = 8'd2; rom_a[35] = 8'd3; rom_a[36] = 8'd4;
    reload_a(n);
    for (int t = 0; t < 5; t++) begin
      send_a(cs[t]);
      write_a(nwr, oerr, seen, vd, dn2, bz2);
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (cap_a[win[j]] !== 8'(ex[t][j]))
          begin failures++; $display("FAIL rotate_cmd%0h_p%0d: got %0d want %0d", cs[t], j, cap_a[win[j]], ex[t][j]); end
      end
    end
  endtask

  task automatic test_clamp();
    int ix [3][3] = '{'{6, 15, 27}, '{27, 28, 6}, '{48, 57, 27}};
    int ev [3][3] = '{'{249, 240, 27}, '{228, 227, 249}, '{207, 198, 228}};
    int n, nwr, oerr;
    bit seen;
    logic vd, dn2, bz2;
    fill_rom_a();
    reload_a(n);
    for (int t = 0; t < 3; t++) begin
      if (t == 0) begin
        for (int i = 0; i < 5; i++) send_a(4'h1);
        for (int i = 0; i < 6; i++) send_a(4'h4);
      end else if (t == 1) begin
        send_a(4'hC);
      end else begin
        for (int i = 0; i < 8; i++) send_a(4'h3);
        for (int i = 0; i < 8; i++) send_a(4'h2);
      end
      send_a(4'hD);
      write_a(nwr, oerr, seen, vd, dn2, bz2);
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (cap_a[ix[t][j]] !== 8'(ev[t][j]))
          begin failures++; $display("FAIL clamp_phase%0d_pix%0d: got %0d want %0d", t, ix[t][j], cap_a[ix[t][j]], ev[t][j]); end
      end
    end
  endtask

  task automatic test_busy_ignore();
    int n, nwr, oerr, bad;
    bit seen;
    logic vd, dn2, bz2, b1, b2;
    fill_rom_a();
    rst_a = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_a = 1'b1;
    cmd_a = 4'hD; cv_a = 1'b1;
    for (int i = 0; i < 50; i++) @(negedge clk);
    cv_a = 1'b0;
    wait_idle_a(n);
    cmd_a = 4'hE; cv_a = 1'b1;
    @(negedge clk);
    cv_a = 1'b0;
    b1 = busy_a;
    @(negedge clk);
    b2 = busy_a;
    write_a(nwr, oerr, seen, vd, dn2, bz2);
    bad = 0;
    for (int k = 0; k < 64; k++) if (cap_a[k] !== 8'(k)) bad++;
    checks += 3;
    if (b1 !== 1'b1) begin failures++; $display("FAIL op_busy_high: got %b want 1", b1); end
    if (b2 !== 1'b0) begin failures++; $display("FAIL op_one_cycle: got %b want 0", b2); end
    if (bad !== 0)   begin failures++; $display("FAIL ignored_cmd_data: got %0d bad pixels want 0", bad); end
  endtask

  task automatic test_reset_mid_write();
    int n, w;
    fill_rom_a();
    wait_idle_a(w);
    cmd_a = 4'h0; cv_a = 1'b1;
    @(negedge clk);
    cv_a = 1'b0;
    n = 0;
    while (!(wv_a === 1'b1 && wa_a === 6'd20) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin failures++; $display("FAIL midwrite_reach_k20: got timeout want IRAM_A=20"); end
    rst_a = 1'b0;
    #1;
    checks += 4;
    if (wv_a !== 1'b0)   begin failures++; $display("FAIL midwrite_valid: got %b want 0", wv_a); end
    if (rd_a !== 1'b1)   begin failures++; $display("FAIL midwrite_rd: got %b want 1", rd_a); end
    if (ra_a !== 6'd0)   begin failures++; $display("FAIL midwrite_irom_a: got %0d want 0", ra_a); end
    if (busy_a !== 1'b1) begin failures++; $display("FAIL midwrite_busy: got %b want 1", busy_a); end
    @(negedge clk);
    rst_a = 1'b1;
    wait_idle_a(n);
    checks++;
    if (n !== 64) begin failures++; $display("FAIL midwrite_reload_cycles: got %0d want 64", n); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] first [64];
    int nwr1, nwr2, oerr, diff, bad;
    bit seen1, seen2;
    logic vd, dn2, bz2;
    write_a(nwr1, oerr, seen1, vd, dn2, bz2);
    first = cap_a;
    write_a(nwr2, oerr, seen2, vd, dn2, bz2);
    diff = 0; bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (cap_a[k] !== first[k]) diff++;
      if (cap_a[k] !== 8'(k)) bad++;
    end
    checks += 4;
    if (nwr1 + nwr2 !== 128)  begin failures++; $display("FAIL b2b_count: got %0d want 128", nwr1 + nwr2); end
    if ({seen1, seen2} !== 2'b11) begin failures++; $display("FAIL b2b_done: got %b want 11", {seen1, seen2}); end
    if (diff !== 0) begin failures++; $display("FAIL b2b_identical: got %0d differences want 0", diff); end
    if (bad !== 0)  begin failures++; $display("FAIL b2b_data: got %0d bad pixels want 0", bad); end
  endtask

  task automatic test_param();
    int n, nwr, bad;
    bit seen;
    for (int k = 0; k < 64; k++) rom_b[k] = 10'(k);
    rom_b[39] = 10'd1023; rom_b[40] = 10'd1023; rom_b[55] = 10'd1023; rom_b[56] = 10'd1023;
    rst_b = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_b = 1'b1;
    wait_idle_b(n);
    checks++;
    if (n !== 64) begin failures++; $display("FAIL p_load_cycles: got %0d want 64", n); end
    // reset origin at index 23: window 23,24,39,40
    send_b(4'hD);
    write_b(nwr, seen);
    checks += 3;
    if (cap_b[23] !== 10'd1000) begin failures++; $display("FAIL p_origin_p0: got %0d want 1000", cap_b[23]); end
    if (cap_b[40] !== 10'd0)    begin failures++; $display("FAIL p_origin_p3: got %0d want 0", cap_b[40]); end
    if (nwr !== 64)             begin failures++; $display("FAIL p_write_count: got %0d want 64", nwr); end
    send_b(4'hD);
    for (int i = 0; i < 3; i++) send_b(4'h2);
    send_b(4'h7);
    write_b(nwr, seen);
    checks += 2;
    if (cap_b[39] !== 10'd1023) begin failures++; $display("FAIL p_avg_p0: got %0d want 1023", cap_b[39]); end
    if (cap_b[56] !== 10'd1023) begin failures++; $display("FAIL p_avg_p3: got %0d want 1023", cap_b[56]); end
    send_b(4'hD);
    write_b(nwr, seen);
    bad = 0;
    for (int k = 0; k < 64; k++)
      if (k != 39 && k != 40 && k != 55 && k != 56 && cap_b[k] !== 10'(k)) bad++;
    checks += 4;
    if (cap_b[40] !== 10'd0) begin failures++; $display("FAIL p_clamp_p1: got %0d want 0", cap_b[40]); end
    if (cap_b[55] !== 10'd0) begin failures++; $display("FAIL p_clamp_p2: got %0d want 0", cap_b[55]); end
    if (bad !== 0)           begin failures++; $display("FAIL p_others: got %0d bad pixels want 0", bad); end
    if (seen !== 1'b1)       begin failures++; $display("FAIL p_done: got %b want 1", seen); end
  endtask

  initial begin
    rst_a = 1'b0; cmd_a = 4'h0; cv_a = 1'b0;
    rst_b = 1'b0; cmd_b = 4'h0; cv_b = 1'b0;
    for (int k = 0; k < 64; k++) begin
      rom_a[k] = 8'(k);
      rom_b[k] = 10'(k);
    end
    test_reset();
    test_load_write();
    test_reduce();
    test_rotate();
    test_clamp();
    test_busy_ignore();
    test_reset_mid_write();
    test_back_to_back();
    test_param();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
